// File: rtl/loadstore.sv
// loadstore: memory-access stage, one Wishbone B4 pipelined beat per access.
// Optional ECAP5_DPROC_LS_TIMEOUT_EN aborts a transaction after 255 cycles.
module loadstore (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        input_ready_o,
  input  logic        input_valid_i,
  input  logic [31:0] result_i,
  input  logic        ls_enable_i,
  input  logic        ls_write_i,
  input  logic [31:0] ls_write_data_i,
  input  logic [3:0]  ls_sel_i,
  input  logic        ls_unsigned_load_i,
  input  logic        reg_write_i,
  input  logic [4:0]  reg_addr_i,
  output logic        output_valid_o,
  output logic        reg_write_o,
  output logic [4:0]  reg_addr_o,
  output logic [31:0] reg_data_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    WAIT_ACK
  } state_t;

  state_t      state;
  logic [1:0]  off_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic        uns_q;
  logic        rw_q;
  logic [4:0]  ra_q;

  logic        done;
  logic        abort;
  logic        busy;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign input_ready_o = (state == IDLE);
  assign busy = (state == REQUEST) || (state == WAIT_ACK);

  // Ack accepted either together with the stall release or while waiting.
  assign done = ((state == REQUEST) && !wb_stall_i && wb_ack_i) ||
                ((state == WAIT_ACK) && wb_ack_i);

`ifdef ECAP5_DPROC_LS_TIMEOUT_EN
  logic [7:0] cnt;

  assign abort = busy && !done && (cnt == 8'd254);

  // Cycle counter for the current transaction, cleared on each request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= 8'd0;
    end else if (state == IDLE) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  // Align the returned word to the access and extend it.
  always_comb begin
    shifted = wb_dat_i >> {off_q, 3'b000};
    load_data = shifted;
    unique case (1'b1)
      (sel_q == 4'b0001): begin
        load_data = uns_q ? {24'd0, shifted[7:0]}
                          : {{24{shifted[7]}}, shifted[7:0]};
      end
      (sel_q == 4'b0011): begin
        load_data = uns_q ? {16'd0, shifted[15:0]}
                          : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: load_data = shifted;
    endcase
  end

  // Stage FSM with registered bus and write-back outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      off_q          <= 2'd0;
      sel_q          <= 4'd0;
      we_q           <= 1'b0;
      uns_q          <= 1'b0;
      rw_q           <= 1'b0;
      ra_q           <= 5'd0;
      output_valid_o <= 1'b0;
      reg_write_o    <= 1'b0;
      reg_addr_o     <= 5'd0;
      reg_data_o     <= 32'd0;
      wb_adr_o       <= 32'd0;
      wb_dat_o       <= 32'd0;
      wb_we_o        <= 1'b0;
      wb_sel_o       <= 4'd0;
      wb_stb_o       <= 1'b0;
      wb_cyc_o       <= 1'b0;
    end else begin
      output_valid_o <= 1'b0;
      reg_write_o    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (input_valid_i && ls_enable_i) begin
            off_q    <= result_i[1:0];
            sel_q    <= ls_sel_i;
            we_q     <= ls_write_i;
            uns_q    <= ls_unsigned_load_i;
            rw_q     <= reg_write_i;
            ra_q     <= reg_addr_i;
            wb_adr_o <= {result_i[31:2], 2'b00};
            wb_sel_o <= ls_sel_i << result_i[1:0];
            wb_dat_o <= ls_write_data_i << {result_i[1:0], 3'b000};
            wb_we_o  <= ls_write_i;
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
            state    <= REQUEST;
          end else if (input_valid_i) begin
            output_valid_o <= 1'b1;
            reg_write_o    <= reg_write_i;
            reg_addr_o     <= reg_addr_i;
            reg_data_o     <= result_i;
          end
        end
        REQUEST: begin
          if (!wb_stall_i) begin
            wb_stb_o <= 1'b0;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
        end
        default: state <= IDLE;
      endcase
      if (done || abort) begin
        state          <= IDLE;
        wb_stb_o       <= 1'b0;
        wb_cyc_o       <= 1'b0;
        output_valid_o <= 1'b1;
        reg_write_o    <= rw_q && !we_q;
        reg_addr_o     <= ra_q;
        reg_data_o     <= (abort || we_q) ? 32'd0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_loadstore.sv
// tb_loadstore: directed and random checks of the loadstore stage
// against an arithmetic model of alignment, extension and timing.
module tb_loadstore;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        input_ready_o;
  logic        input_valid_i;
  logic [31:0] result_i;
  logic        ls_enable_i;
  logic        ls_write_i;
  logic [31:0] ls_write_data_i;
  logic [3:0]  ls_sel_i;
  logic        ls_unsigned_load_i;
  logic        reg_write_i;
  logic [4:0]  reg_addr_i;
  logic        output_valid_o;
  logic        reg_write_o;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_stall_i;
  logic        wb_ack_i;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  loadstore dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .input_ready_o(input_ready_o),
    .input_valid_i(input_valid_i),
    .result_i(result_i),
    .ls_enable_i(ls_enable_i),
    .ls_write_i(ls_write_i),
    .ls_write_data_i(ls_write_data_i),
    .ls_sel_i(ls_sel_i),
    .ls_unsigned_load_i(ls_unsigned_load_i),
    .reg_write_i(reg_write_i),
    .reg_addr_i(reg_addr_i),
    .output_valid_o(output_valid_o),
    .reg_write_o(reg_write_o),
    .reg_addr_o(reg_addr_o),
    .reg_data_o(reg_data_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_stall_i(wb_stall_i),
    .wb_ack_i(wb_ack_i)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(logic [31:0] d,
      logic [1:0] off, logic [3:0] sel, logic uns);
    int nb;
    logic [31:0] v, m;
    nb = (sel == 4'b0001) ? 1 : (sel == 4'b0011) ? 2 : 4;
    v = d >> (8 * off);
    if (nb == 4) return v;
    m = (32'd1 << (8 * nb)) - 32'd1;
    v = v & m;
    if (!uns && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  task automatic pass_thru(logic [31:0] r, logic rw, logic [4:0] ra);
    chk("pt_ready", {31'd0, input_ready_o}, 1);
    input_valid_i = 1'b1; ls_enable_i = 1'b0;
    result_i = r; reg_write_i = rw; reg_addr_i = ra;
    @(negedge clk_i);
    input_valid_i = 1'b0;
    chk("pt_valid", {31'd0, output_valid_o}, 1);
    chk("pt_rw", {31'd0, reg_write_o}, {31'd0, rw});
    chk("pt_addr", {27'd0, reg_addr_o}, {27'd0, ra});
    chk("pt_data", reg_data_o, r);
    chk("pt_cyc", {31'd0, wb_cyc_o}, 0);
  endtask

  task automatic bubble();
    input_valid_i = 1'b0;
    result_i = $urandom; reg_write_i = 1'b1;
    @(negedge clk_i);
    chk("bub_valid", {31'd0, output_valid_o}, 0);
    chk("bub_rw", {31'd0, reg_write_o}, 0);
  endtask

  task automatic txn(logic [31:0] a, logic [3:0] sel,
      logic [31:0] wd, logic we, logic uns, logic rw,
      logic [4:0] ra, int ns, int nw, logic [31:0] rd);
    logic [31:0] e_dat;
    logic [3:0]  e_sel;
    logic [31:0] e_reg;
    e_sel = 4'((8'(sel) << a[1:0]) & 8'h0F);
    e_dat = wd << (8 * a[1:0]);
    e_reg = we ? 32'd0 : exp_load(rd, a[1:0], sel, uns);
    chk("tx_ready_in", {31'd0, input_ready_o}, 1);
    input_valid_i = 1'b1; ls_enable_i = 1'b1;
    result_i = a; ls_sel_i = sel; ls_write_data_i = wd;
    ls_write_i = we; ls_unsigned_load_i = uns;
    reg_write_i = rw; reg_addr_i = ra;
    @(negedge clk_i);
    input_valid_i = 1'b0;
    for (int i = 0; i <= ns; i++) begin
      chk("tx_stb", {31'd0, wb_stb_o}, 1);
      chk("tx_cyc", {31'd0, wb_cyc_o}, 1);
      chk("tx_adr", wb_adr_o, {a[31:2], 2'b00});
      chk("tx_sel", {28'd0, wb_sel_o}, {28'd0, e_sel});
      chk("tx_dat", wb_dat_o, e_dat);
      chk("tx_we", {31'd0, wb_we_o}, {31'd0, we});
      chk("tx_busy", {31'd0, input_ready_o}, 0);
      wb_stall_i = (i < ns);
      if (i == ns && nw == 0) begin
        wb_ack_i = 1'b1; wb_dat_i = rd;
      end
      @(negedge clk_i);
    end
    wb_stall_i = 1'b0;
    for (int j = 1; j <= nw; j++) begin
      chk("wa_cyc", {31'd0, wb_cyc_o}, 1);
      chk("wa_stb", {31'd0, wb_stb_o}, 0);
      chk("wa_busy", {31'd0, input_ready_o}, 0);
      chk("wa_ov", {31'd0, output_valid_o}, 0);
      wb_ack_i = (j == nw);
      wb_dat_i = (j == nw) ? rd : $urandom;
      @(negedge clk_i);
    end
    wb_ack_i = 1'b0; wb_dat_i = $urandom;
    chk("cp_valid", {31'd0, output_valid_o}, 1);
    chk("cp_rw", {31'd0, reg_write_o}, {31'd0, rw && !we});
    chk("cp_addr", {27'd0, reg_addr_o}, {27'd0, ra});
    chk("cp_data", reg_data_o, e_reg);
    chk("cp_cyc", {31'd0, wb_cyc_o}, 0);
    chk("cp_ready", {31'd0, input_ready_o}, 1);
  endtask

  logic [3:0] sels [3] = '{4'b0001, 4'b0011, 4'b1111};

  initial begin
    rst_i = 1'b0;
    input_valid_i = 1'b0; result_i = '0; ls_enable_i = 1'b0;
    ls_write_i = 1'b0; ls_write_data_i = '0; ls_sel_i = '0;
    ls_unsigned_load_i = 1'b0; reg_write_i = 1'b0; reg_addr_i = '0;
    wb_dat_i = '0; wb_stall_i = 1'b0; wb_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_ov", {31'd0, output_valid_o}, 0);
    chk("rst_cyc", {31'd0, wb_cyc_o}, 0);
    chk("rst_stb", {31'd0, wb_stb_o}, 0);
    chk("rst_data", reg_data_o, 0);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", {31'd0, input_ready_o}, 1);

    pass_thru(32'h1234_5678, 1'b1, 5'd5);
    bubble();
    txn(32'h103, 4'b0001, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7,
        0, 1, 32'h80AA_BBCC);
    txn(32'h202, 4'b0011, 32'h0000_BEEF, 1'b1, 1'b0, 1'b1,
        5'd9, 0, 1, 32'h0);
    txn(32'h300, 4'b1111, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3,
        3, 1, 32'hCAFE_F00D);
    txn(32'h401, 4'b0011, 32'h0, 1'b0, 1'b1, 1'b1, 5'd4,
        0, 0, 32'h0012_3400);

    wb_ack_i = 1'b1;
    @(negedge clk_i);
    wb_ack_i = 1'b0;
    chk("stray_ack", {31'd0, output_valid_o}, 0);

    input_valid_i = 1'b1; ls_enable_i = 1'b1; result_i = 32'h40;
    ls_sel_i = 4'hF; ls_write_i = 1'b0; reg_write_i = 1'b1;
    @(negedge clk_i);
    input_valid_i = 1'b0;
    @(negedge clk_i);
    chk("mid_cyc", {31'd0, wb_cyc_o}, 1);
    rst_i = 1'b0;
    #1;
    chk("arst_cyc", {31'd0, wb_cyc_o}, 0);
    chk("arst_stb", {31'd0, wb_stb_o}, 0);
    chk("arst_ov", {31'd0, output_valid_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b1; wb_ack_i = 1'b1;
    @(negedge clk_i);
    wb_ack_i = 1'b0;
    chk("late_ack_ov", {31'd0, output_valid_o}, 0);
    chk("late_ack_cyc", {31'd0, wb_cyc_o}, 0);
    chk("rel_ready", {31'd0, input_ready_o}, 1);

    for (int k = 0; k < 40; k++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        pass_thru($urandom, 1'($urandom), 5'($urandom));
      end else if (kind == 1) begin
        bubble();
      end else begin
        txn($urandom, sels[$urandom_range(0, 2)], $urandom,
            1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom);
      end
    end

`ifdef ECAP5_DPROC_LS_TIMEOUT_EN
    begin
      int nbusy;
      nbusy = 0;
      input_valid_i = 1'b1; ls_enable_i = 1'b1; result_i = 32'h80;
      ls_sel_i = 4'hF; ls_write_i = 1'b0; reg_write_i = 1'b1;
      @(negedge clk_i);
      input_valid_i = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if (wb_cyc_o !== 1'b1) break;
        nbusy++;
        @(negedge clk_i);
      end
      chk("to_cycles", nbusy, 255);
      chk("to_cyc", {31'd0, wb_cyc_o}, 0);
      chk("to_ov", {31'd0, output_valid_o}, 1);
      chk("to_data", reg_data_o, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
